// File: rtl/sm2c_seq_divider.sv
// Iterative restoring divider for signed-magnitude or 2's-complement operands.
// One subtract-and-restore step per clock; quotient and remainder are returned
// in the same format as the operands.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   div_in_valid/div_in_ready operand handshake (ready only while idle)
//   div_dividend, div_divisor operands, WIDTH bits including sign
//   div_sm2c_sel              0 = 2's complement, 1 = signed magnitude
//   div_out_valid/ready       result handshake
//   div_quotient, div_remainder results, same format as the operands
//   div_by_zero               divisor magnitude was zero
//   div_overflow              2C quotient not representable (MIN / -1)
module sm2c_seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in_valid,
    output logic             div_in_ready,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    input  logic             div_sm2c_sel,
    output logic             div_out_valid,
    input  logic             div_out_ready,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_by_zero,
    output logic             div_overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONV = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] dd_q, dd_d, dv_q, dv_d;
    logic             sel_q, sel_d;
    logic             sgn_dd_q, sgn_dd_d, sgn_dv_q, sgn_dv_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] dvm_q, dvm_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    // Working values for conversion, iteration and sign fix-up
    logic [WIDTH-1:0] ddm, dvm, sh_rem, q_fix, r_fix;
    logic [WIDTH:0]   trial;
    logic             q_sgn;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dd_q        <= '0;
            dv_q        <= '0;
            sel_q       <= 1'b0;
            sgn_dd_q    <= 1'b0;
            sgn_dv_q    <= 1'b0;
            zero_q      <= 1'b0;
            dvm_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            remo_q      <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dd_q        <= dd_d;
            dv_q        <= dv_d;
            sel_q       <= sel_d;
            sgn_dd_q    <= sgn_dd_d;
            sgn_dv_q    <= sgn_dv_d;
            zero_q      <= zero_d;
            dvm_q       <= dvm_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quot_q      <= quot_d;
            remo_q      <= remo_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        dd_d     = dd_q;
        dv_d     = dv_q;
        sel_d    = sel_q;
        sgn_dd_d = sgn_dd_q;
        sgn_dv_d = sgn_dv_q;
        zero_d   = zero_q;
        dvm_d    = dvm_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        remo_d   = remo_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;

        // SM magnitude drops the sign bit, so -0 becomes +0; 2C MIN maps to 2^(W-1)
        ddm = sel_q ? {1'b0, dd_q[WIDTH-2:0]} : (dd_q[WIDTH-1] ? WIDTH'(-dd_q) : dd_q);
        dvm = sel_q ? {1'b0, dv_q[WIDTH-2:0]} : (dv_q[WIDTH-1] ? WIDTH'(-dv_q) : dv_q);

        // Partial remainder stays below the divisor magnitude, so the shift fits in WIDTH bits
        sh_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        trial  = {1'b0, sh_rem} - {1'b0, dvm_q};

        q_sgn = sgn_dd_q ^ sgn_dv_q;
        if (sel_q) begin
            q_fix = (quo_q == '0) ? '0 : {q_sgn, quo_q[WIDTH-2:0]};
            r_fix = (rem_q == '0) ? '0 : {sgn_dd_q, rem_q[WIDTH-2:0]};
        end else begin
            q_fix = q_sgn    ? WIDTH'(-quo_q) : quo_q;
            r_fix = sgn_dd_q ? WIDTH'(-rem_q) : rem_q;
        end

        case (state_q)
            S_IDLE: begin
                if (div_in_valid && in_ready_q) begin
                    dd_d    = div_dividend;
                    dv_d    = div_divisor;
                    sel_d   = div_sm2c_sel;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                sgn_dd_d = dd_q[WIDTH-1];
                sgn_dv_d = dv_q[WIDTH-1];
                dvm_d    = dvm;
                rem_d    = '0;
                quo_d    = ddm;
                cnt_d    = CW'(WIDTH);
                zero_d   = (dvm == '0);
                // Divide-by-zero skips the iterations but still passes FIX,
                // giving a fixed two-step result latency
                state_d  = (dvm == '0) ? S_FIX : S_ITER;
            end
            S_ITER: begin
                rem_d = trial[WIDTH] ? sh_rem : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zero_q) begin
                    quot_d = '1;
                    remo_d = dd_q;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    quot_d = q_fix;
                    remo_d = r_fix;
                    dbz_d  = 1'b0;
                    ovf_d  = !sel_q && (dd_q == MIN_NEG) && (dv_q == '1);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (div_out_ready) begin
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign div_in_ready  = in_ready_q;
    assign div_out_valid = out_valid_q;
    assign div_quotient  = quot_q;
    assign div_remainder = remo_q;
    assign div_by_zero   = dbz_q;
    assign div_overflow  = ovf_q;

endmodule

// File: tb/tb_sm2c_seq_divider.sv
// Self-checking bench for sm2c_seq_divider at WIDTH = 8: directed cases with
// literal expectations plus randomized operands against an arithmetic model.
module tb_sm2c_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_in_valid, div_in_ready;
    logic [W-1:0] div_dividend, div_divisor;
    logic         div_sm2c_sel;
    logic         div_out_valid, div_out_ready;
    logic [W-1:0] div_quotient, div_remainder;
    logic         div_by_zero, div_overflow;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q, exp_r;
    logic         exp_dbz, exp_ovf;

    sm2c_seq_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_in_valid (div_in_valid),
        .div_in_ready (div_in_ready),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_sm2c_sel (div_sm2c_sel),
        .div_out_valid(div_out_valid),
        .div_out_ready(div_out_ready),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_by_zero  (div_by_zero),
        .div_overflow (div_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: integer division of magnitudes, truncation toward zero
    function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sel,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output logic ovf);
        int sa, sb, ma, mb, qm, rm, qs;
        sa = int'(dd[W-1]);
        sb = int'(dv[W-1]);
        if (sel) begin
            ma = int'(dd) % 128;
            mb = int'(dv) % 128;
        end else begin
            ma = (sa != 0) ? 256 - int'(dd) : int'(dd);
            mb = (sb != 0) ? 256 - int'(dv) : int'(dv);
        end
        if (mb == 0) begin
            q = 8'hFF; r = dd; dbz = 1'b1; ovf = 1'b0;
            return;
        end
        qm = ma / mb;
        rm = ma % mb;
        qs = sa ^ sb;
        dbz = 1'b0;
        if (sel) begin
            q = (qm == 0) ? 8'h00 : 8'(qs * 128 + qm);
            r = (rm == 0) ? 8'h00 : 8'(sa * 128 + rm);
            ovf = 1'b0;
        end else begin
            q = 8'((qs != 0) ? 256 - qm : qm);
            r = 8'((sa != 0) ? 256 - rm : rm);
            ovf = (dd == 8'h80) && (dv == 8'hFF);
        end
    endfunction

    // Continuous result checker: whenever a result is presented it must match the model
    always @(negedge clk) begin
        if (!rst && div_out_valid) begin
            chk("mon_quotient",  64'(div_quotient),  64'(exp_q));
            chk("mon_remainder", 64'(div_remainder), 64'(exp_r));
            chk("mon_by_zero",   64'(div_by_zero),   64'(exp_dbz));
            chk("mon_overflow",  64'(div_overflow),  64'(exp_ovf));
            chk("mon_in_ready_busy", 64'(div_in_ready), 64'd0);
        end
    end

    // One operation: accept, measure latency, optional literal check, hold, release
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sel,
                          input logic lit, input logic [W-1:0] lq, input logic [W-1:0] lr,
                          input logic ld, input logic lo, input int hold);
        int n;
        n = 0;
        while (!div_in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 64'(div_in_ready), 64'd1);
        model(dd, dv, sel, exp_q, exp_r, exp_dbz, exp_ovf);
        div_dividend = dd;
        div_divisor  = dv;
        div_sm2c_sel = sel;
        div_in_valid = 1'b1;
        @(posedge clk); #1;
        div_in_valid = 1'b0;
        div_dividend = W'($urandom);
        div_divisor  = W'($urandom);
        div_sm2c_sel = 1'($urandom);
        n = 0;
        while (!div_out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), exp_dbz ? 64'd2 : 64'(W + 2));
        if (lit) begin
            chk("lit_quotient",  64'(div_quotient),  64'(lq));
            chk("lit_remainder", 64'(div_remainder), 64'(lr));
            chk("lit_by_zero",   64'(div_by_zero),   64'(ld));
            chk("lit_overflow",  64'(div_overflow),  64'(lo));
        end
        for (int i = 0; i < hold; i++) begin
            div_in_valid = 1'($urandom);
            div_dividend = W'($urandom);
            div_divisor  = W'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(div_out_valid), 64'd1);
        end
        div_in_valid  = 1'b0;
        div_out_ready = 1'b1;
        @(posedge clk); #1;
        div_out_ready = 1'b0;
        chk("release_out_valid", 64'(div_out_valid), 64'd0);
        chk("release_in_ready",  64'(div_in_ready),  64'd1);
    endtask

    initial begin
        logic [W-1:0] rdd, rdv;
        logic         rsel;
        rst = 1'b1;
        div_in_valid = 1'b0;
        div_out_ready = 1'b0;
        div_dividend = '0;
        div_divisor = '0;
        div_sm2c_sel = 1'b0;
        exp_q = '0; exp_r = '0; exp_dbz = 1'b0; exp_ovf = 1'b0;
        #22;
        chk("rst_in_ready",  64'(div_in_ready),  64'd1);
        chk("rst_out_valid", 64'(div_out_valid), 64'd0);
        chk("rst_quotient",  64'(div_quotient),  64'd0);
        chk("rst_remainder", 64'(div_remainder), 64'd0);
        chk("rst_flags",     64'({div_by_zero, div_overflow}), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'd100, 8'd7, 1'b0, 1'b1, 8'h0E, 8'h02, 1'b0, 1'b0, 0);
        run_op(8'h9C,  8'd7, 1'b0, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 0);
        run_op(8'h85, 8'h02, 1'b1, 1'b1, 8'h82, 8'h81, 1'b0, 1'b0, 0);
        run_op(8'h83, 8'h05, 1'b1, 1'b1, 8'h00, 8'h83, 1'b0, 1'b0, 0);
        run_op(8'h80, 8'h03, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'h2A, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h2A, 1'b1, 1'b0, 0);
        run_op(8'h2A, 8'h80, 1'b1, 1'b1, 8'hFF, 8'h2A, 1'b1, 1'b0, 0);
        run_op(8'h80, 8'hFF, 1'b0, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'hFF, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 0);
        // Backpressure with toggling inputs while the result is held
        run_op(8'd50, 8'hF9, 1'b0, 1'b1, 8'hF9, 8'h01, 1'b0, 1'b0, 5);

        // Reset during the third iteration cycle discards the operation
        div_dividend = 8'd77; div_divisor = 8'd5; div_sm2c_sel = 1'b0;
        div_in_valid = 1'b1;
        @(posedge clk); #1;
        div_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(div_out_valid), 64'd0);
        chk("midrst_in_ready",  64'(div_in_ready),  64'd1);
        chk("midrst_outputs",   64'({div_quotient, div_remainder, div_by_zero, div_overflow}), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'd127, 8'hFD, 1'b0, 1'b1, 8'hD6, 8'h01, 1'b0, 1'b0, 0);

        // Randomized operands, biased toward zero divisors and extreme values
        for (int i = 0; i < 200; i++) begin
            rdd  = W'($urandom);
            rdv  = W'($urandom);
            rsel = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rdv = rsel ? {1'($urandom), 7'd0} : 8'h00;
                1: rdd = 8'h80;
                2: rdv = 8'hFF;
                3: rdv = 8'h01;
                default: ;
            endcase
            run_op(rdd, rdv, rsel, 1'b0, '0, '0, 1'b0, 1'b0, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
